// File: rtl/accel_pkg.sv
// Shared types and sizing helpers for the weight-load path of the PE array.
//  loader_state_e : weight_tile_loader FSM encoding
//  DW_DEF         : default signed weight width
//  ROW_CNT_W/COL_CNT_W : counter widths for the default 8x8 array
//  cnt_w()        : counter width for an arbitrary count, never narrower than 1 bit
package accel_pkg;

   typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} loader_state_e;

   localparam int DW_DEF     = 8;
   localparam int N_ROWS_DEF = 8;
   localparam int N_COLS_DEF = 8;
   localparam int ROW_CNT_W  = $clog2(N_ROWS_DEF);
   localparam int COL_CNT_W  = $clog2(N_COLS_DEF);

   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/weight_skew_line.sv
// Fixed-depth shift register that delays one column's weight so it meets the
// load_weight ripple at the matching PE. Shifts every cycle, no enable.
//  clk : clock
//  rst : synchronous active-high reset, clears every stage
//  d   : signed weight entering the line
//  q   : signed weight leaving the last stage (DEPTH cycles later)
module weight_skew_line #(
   parameter int DEPTH = 1,
   parameter int DW    = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic signed [DW-1:0] d,
   output logic signed [DW-1:0] q
);

   logic signed [DW-1:0] stage_p [DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) stage_p[i] <= '0;
      end else begin
         stage_p[0] <= d;
         for (int i = 1; i < DEPTH; i++) stage_p[i] <= stage_p[i-1];
      end
   end

   assign q = stage_p[DEPTH-1];

endmodule

// File: rtl/weight_tile_loader.sv
// Loads one weight tile into the weight-stationary PE array, one row per
// valid/ready beat. Pulses the accepted row's left-edge load_weight and drives
// each column bus skewed by its column index so the data meets the 1-cycle/PE
// load_weight ripple. compute_inhibit keeps MAC enable off while any PE loads.
//  clk             : clock
//  rst             : synchronous active-high reset
//  start           : begin a tile (honoured only when idle)
//  w_valid/w_ready : weight row handshake
//  w_data          : weight row, element c at [c*DW +: DW], signed
//  load_row        : one-hot row load pulse to PE(r,0).load_weight
//  b_col           : per-column weight bus to b_in of every PE in column c
//  compute_inhibit : high from the cycle after start through the done cycle
//  busy            : FSM not idle
//  done            : one-cycle pulse once the whole tile is resident
module weight_tile_loader
   import accel_pkg::*;
#(
   parameter int N_ROWS = 8,
   parameter int N_COLS = 8,
   parameter int DW     = DW_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   w_valid,
   output logic                   w_ready,
   input  logic [N_COLS*DW-1:0]   w_data,
   output logic [N_ROWS-1:0]      load_row,
   output logic [N_COLS*DW-1:0]   b_col,
   output logic                   compute_inhibit,
   output logic                   busy,
   output logic                   done
);

   localparam int RCW = cnt_w(N_ROWS);
   localparam int DCW = cnt_w(N_COLS);

   loader_state_e  state;
   logic [RCW-1:0] row_cnt;
   logic [DCW-1:0] drain_cnt;
   logic           accept;

   // w_ready is a registered copy of (state == LOAD), so this is the beat qualifier
   assign accept = w_valid & w_ready;

   // Column skew: column c sees its element c+1 cycles after the accept,
   // exactly when the load_weight ripple reaches PE(r,c). Idle cycles shift in 0.
   for (genvar c = 0; c < N_COLS; c++) begin : g_col
      logic signed [DW-1:0] line_in;
      logic signed [DW-1:0] line_out;

      assign line_in = accept ? w_data[c*DW +: DW] : '0;

      weight_skew_line #(
         .DEPTH (c + 1),
         .DW    (DW)
      ) u_line (
         .clk (clk),
         .rst (rst),
         .d   (line_in),
         .q   (line_out)
      );

      assign b_col[c*DW +: DW] = line_out;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         row_cnt         <= '0;
         drain_cnt       <= '0;
         load_row        <= '0;
         w_ready         <= 1'b0;
         busy            <= 1'b0;
         compute_inhibit <= 1'b0;
         done            <= 1'b0;
      end else begin
         // Row pulse lands one cycle after the accept, aligned with column 0's data
         load_row <= accept ? (N_ROWS'(1) << row_cnt) : '0;
         done     <= 1'b0;

         case (state)
            IDLE: begin
               if (start) begin
                  state           <= LOAD;
                  row_cnt         <= '0;
                  w_ready         <= 1'b1;
                  busy            <= 1'b1;
                  compute_inhibit <= 1'b1;
               end
            end

            LOAD: begin
               if (accept) begin
                  if (row_cnt == RCW'(N_ROWS - 1)) begin
                     state     <= DRAIN;
                     row_cnt   <= '0;
                     drain_cnt <= '0;
                     w_ready   <= 1'b0;
                  end else begin
                     row_cnt <= row_cnt + 1'b1;
                  end
               end
            end

            // Wait for the last row to ripple out to the far column
            DRAIN: begin
               drain_cnt <= drain_cnt + 1'b1;
               if (drain_cnt == DCW'(N_COLS - 1)) begin
                  state <= DONE;
                  done  <= 1'b1;
               end
            end

            DONE: begin
               state           <= IDLE;
               busy            <= 1'b0;
               compute_inhibit <= 1'b0;
            end

            default: begin
               state           <= IDLE;
               w_ready         <= 1'b0;
               busy            <= 1'b0;
               compute_inhibit <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_weight_tile_loader.sv
// Directed bench for weight_tile_loader on a 4x4 array with 8-bit weights.
// Includes a model of the PE array's load_weight ripple and weight capture.
`timescale 1ns/1ps
module tb_weight_tile_loader;

   localparam int NR = 4;
   localparam int NC = 4;
   localparam int DW = 8;

   logic               clk = 1'b0;
   logic               rst;
   logic               start;
   logic               w_valid;
   logic               w_ready;
   logic [NC*DW-1:0]   w_data;
   logic [NR-1:0]      load_row;
   logic [NC*DW-1:0]   b_col;
   logic               compute_inhibit;
   logic               busy;
   logic               done;

   always #5 clk = ~clk;

   weight_tile_loader #(
      .N_ROWS (NR),
      .N_COLS (NC),
      .DW     (DW)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .w_valid         (w_valid),
      .w_ready         (w_ready),
      .w_data          (w_data),
      .load_row        (load_row),
      .b_col           (b_col),
      .compute_inhibit (compute_inhibit),
      .busy            (busy),
      .done            (done)
   );

   int n_vec = 0;
   int n_err = 0;

   logic signed [DW-1:0] wt [NR][NC];
   logic signed [DW-1:0] pe [NR][NC];
   logic                 lwq [NR][NC];
   logic                 lw  [NR][NC];
   logic                 chk_en = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // PE array model: load_weight enters column 0 from load_row and ripples
   // one PE per cycle; a PE captures its column bus when its load_weight is high.
   always_comb begin
      for (int r = 0; r < NR; r++)
         for (int c = 0; c < NC; c++)
            lw[r][c] = (c == 0) ? load_row[r] : lwq[r][c];
   end

   always @(posedge clk) begin
      for (int r = 0; r < NR; r++) begin
         for (int c = 0; c < NC; c++) begin
            if (rst) lwq[r][c] <= 1'b0;
            else if (c > 0) lwq[r][c] <= lw[r][c-1];
            if (!rst && lw[r][c]) pe[r][c] <= b_col[c*DW +: DW];
         end
      end
   end

   // Continuous properties: row pulse at most one-hot, no PE loads while MAC may run
   always @(negedge clk) begin
      logic any_lw;
      if (chk_en) begin
         any_lw = 1'b0;
         for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++)
               any_lw = any_lw | lw[r][c];
         chk("onehot_load_row", 32'($onehot0(load_row)), 32'd1);
         if (any_lw) chk("load_needs_inhibit", 32'(compute_inhibit), 32'd1);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [NC*DW-1:0] pack(input int r);
      logic [NC*DW-1:0] v;
      for (int c = 0; c < NC; c++) v[c*DW +: DW] = wt[r][c];
      return v;
   endfunction

   task automatic fill_lin(input int base);
      for (int r = 0; r < NR; r++)
         for (int c = 0; c < NC; c++)
            wt[r][c] = 8'(base + 16*r + c);
   endtask

   task automatic fill_pat();
      logic signed [DW-1:0] pat [4];
      pat[0] = -8'sd128; pat[1] = 8'sd127; pat[2] = -8'sd1; pat[3] = 8'sd0;
      for (int r = 0; r < NR; r++)
         for (int c = 0; c < NC; c++)
            wt[r][c] = pat[(r + c) % 4];
   endtask

   task automatic chk_pe(input string tag);
      for (int r = 0; r < NR; r++)
         for (int c = 0; c < NC; c++)
            chk(tag, 32'(pe[r][c]), 32'(wt[r][c]));
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_w_ready"},  32'(w_ready),         32'd0);
      chk({tag, "_load_row"}, 32'(load_row),        32'd0);
      chk({tag, "_b_col"},    32'(b_col),           32'd0);
      chk({tag, "_done"},     32'(done),            32'd0);
      chk({tag, "_inhibit"},  32'(compute_inhibit), 32'd0);
      chk({tag, "_busy"},     32'(busy),            32'd0);
   endtask

   // Runs one tile from the current (idle) cycle, called cycle 0. Optional
   // w_valid gap after row gap_after, extra start pulses at sp1/sp2, and rst
   // asserted during cycle rst_at. Returns the cycle done was seen, or -1.
   task automatic drive_tile(input int gap_after, input int gap_len, input int sp1,
                             input int sp2, input int rst_at, output int done_cyc);
      int ri;
      int gl;
      bit acc;
      ri = 0;
      gl = 0;
      done_cyc = -1;
      start   = 1'b1;
      w_valid = 1'b1;
      w_data  = pack(0);
      for (int cy = 1; cy <= 40; cy++) begin
         acc = w_valid && w_ready;
         if (cy - 1 == rst_at) rst = 1'b1;
         tick();
         rst   = 1'b0;
         start = (cy == sp1) || (cy == sp2);
         if (acc) begin
            ri++;
            if (ri == gap_after) gl = gap_len;
         end
         if (cy - 1 == rst_at) begin
            chk_zero("rst_mid");
            ri = NR;
         end
         if (done) begin
            done_cyc = cy;
            break;
         end
         if (ri < NR && gl == 0) begin
            w_valid = 1'b1;
            w_data  = pack(ri);
         end else begin
            w_valid = 1'b0;
            w_data  = {NC{8'hA5}};
         end
         if (gl > 0) gl--;
      end
      start   = 1'b0;
      w_valid = 1'b0;
      w_data  = '0;
   endtask

   initial begin
      int d;
      int r;
      rst     = 1'b1;
      start   = 1'b1;
      w_valid = 1'b0;
      w_data  = '0;

      // 1: reset with start held, then idle
      repeat (3) tick();
      chk_zero("in_rst");
      rst   = 1'b0;
      start = 1'b0;
      chk_en = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk_zero("idle");
      end

      // 2: back-to-back tile, W[r][c] = 16r+c, w_valid held high
      fill_lin(0);
      start   = 1'b1;
      w_valid = 1'b1;
      w_data  = pack(0);
      for (int cy = 1; cy <= 11; cy++) begin
         tick();
         start = 1'b0;
         if (cy <= 4) w_data = pack(cy - 1);
         chk("t2_load_row", 32'(load_row), (cy >= 2 && cy <= 5) ? (32'd1 << (cy - 2)) : 32'd0);
         chk("t2_done",     32'(done),            32'(cy == 9));
         chk("t2_inhibit",  32'(compute_inhibit), 32'(cy <= 9));
         chk("t2_busy",     32'(busy),            32'(cy <= 9));
         chk("t2_w_ready",  32'(w_ready),         32'(cy <= 4));
         for (int c = 0; c < NC; c++) begin
            r = cy - 2 - c;
            chk("t2_b_col", 32'(b_col[c*DW +: DW]),
                (r >= 0 && r < NR) ? 32'(16*r + c) : 32'd0);
         end
      end
      w_valid = 1'b0;
      chk_pe("t2_pe");

      // 3: two-cycle w_valid gap between rows 1 and 2, extreme values
      tick();
      fill_pat();
      drive_tile(2, 2, -1, -1, -1, d);
      chk("t3_done_cyc", 32'(d), 32'd11);
      chk_pe("t3_pe");

      // 4: start pulses during LOAD and DRAIN are ignored
      tick();
      fill_lin(8'h40);
      drive_tile(0, 0, 2, 6, -1, d);
      chk("t4a_done_cyc", 32'(d), 32'd9);
      chk_pe("t4a_pe");
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("t4_no_done", 32'(done), 32'd0);
         chk("t4_idle",    32'(busy), 32'd0);
      end
      fill_lin(8'h83);
      drive_tile(0, 0, -1, -1, -1, d);
      chk("t4b_done_cyc", 32'(d), 32'd9);
      chk_pe("t4b_pe");
      tick();
      fill_lin(8'hC7);
      drive_tile(0, 0, -1, -1, -1, d);
      chk("t4c_done_cyc", 32'(d), 32'd9);
      chk_pe("t4c_pe");

      // 5: reset during DRAIN abandons the tile, then a fresh tile loads
      tick();
      fill_lin(8'h11);
      drive_tile(0, 0, -1, -1, 6, d);
      chk("t5_no_done", 32'(d), 32'hFFFF_FFFF);
      tick();
      fill_lin(8'h25);
      drive_tile(0, 0, -1, -1, -1, d);
      chk("t5b_done_cyc", 32'(d), 32'd9);
      chk_pe("t5b_pe");

      tick();
      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
